// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths and loader FSM states
package program_loader_pkg;
  localparam int WORD = 32;
  localparam int HALF_WORD = 16;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, HOLD, RUN} loader_state_e;
endpackage

// File: rtl/program_loader_hold_counter.sv
// loader_hold_counter: loadable down-counter with zero flag for the reset-hold window
module loader_hold_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams halfwords into instruction memory then releases CPU reset; PROGRAM_LOADER_CHECKSUM_EN adds a load checksum
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_STEP = 2,
  parameter int MAX_HALFWORDS = 1024,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int LEN_W = $clog2(MAX_HALFWORDS + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     length_i,
  input  logic [WORD-1:0]      base_addr_i,
  input  logic                 data_valid_i,
  input  logic [HALF_WORD-1:0] data_i,
  output logic                 data_ready_o,
  output logic                 mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  input  logic [HALF_WORD-1:0] expected_sum_i,
  output logic                 checksum_fail_o,
`endif
  output logic                 error_o
);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  loader_state_e state, nstate;
  logic [WORD-1:0] addr;
  logic [LEN_W-1:0] count;
  logic hold_done, sum_bad;
  logic len_ok, accept, beat;
  assign len_ok = length_i != '0 && length_i <= LEN_W'(MAX_HALFWORDS);
  assign accept = start_i && len_ok && (state == IDLE || state == RUN);
  assign beat = state == LOAD && data_valid_i && data_ready_o;
  loader_hold_counter #(.W(HW)) u_hold (
    .clk(clk_i),
    .rst(reset_i),
    .load(state == FLUSH),
    .dec(state == HOLD),
    .load_val(HW'(RESET_HOLD_CYCLES - 1)),
    .zero(hold_done)
  );
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, RUN: nstate = accept ? LOAD : state;
      LOAD:      nstate = beat && count == LEN_W'(1) ? FLUSH : LOAD;
      FLUSH:     nstate = sum_bad ? IDLE : HOLD;
      HOLD:      nstate = hold_done ? RUN : HOLD;
      default:   nstate = IDLE;
    endcase
  end
  // Status outputs follow the next state so they stay registered yet line up with it
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      data_ready_o <= 1'b0;
      mem_write_en_o <= 1'b0;
      instruction_o <= '0;
      instruction_addr_o <= '0;
      cpu_reset_o <= 1'b1;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      addr <= '0;
      count <= '0;
    end else begin
      state <= nstate;
      data_ready_o <= nstate == LOAD;
      busy_o <= nstate inside {LOAD, FLUSH, HOLD};
      done_o <= nstate == RUN;
      cpu_reset_o <= nstate != RUN;
      error_o <= start_i && !accept;
      mem_write_en_o <= beat;
      if (beat) begin
        instruction_o <= data_i;
        instruction_addr_o <= addr;
        addr <= addr + WORD'(ADDR_STEP);
        count <= count - 1'b1;
      end
      if (accept) begin
        addr <= base_addr_i;
        count <= length_i;
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [HALF_WORD-1:0] sum, exp_sum;
  assign sum_bad = sum != exp_sum;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      sum <= '0;
      exp_sum <= '0;
      checksum_fail_o <= 1'b0;
    end else begin
      if (beat) sum <= sum + data_i;
      if (accept) begin
        sum <= '0;
        exp_sum <= expected_sum_i;
        checksum_fail_o <= 1'b0;
      end
      if (state == FLUSH && sum_bad) checksum_fail_o <= 1'b1;
    end
`else
  assign sum_bad = 1'b0;
`endif
endmodule
